// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter
// Lets the fetch unit (IF) and the load/store unit (LS) share one single-port
// memory. Only one transaction is outstanding at a time, and each
// transaction has a timeout. The response is steered back to the requester
// that owns the transaction.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants when both
// requesters ask in the same cycle. Without it, LS always wins a contest.
//
// Handshake: a requester holds req (and its fields) until it sees gnt. gnt is
// a one-cycle, combinational pulse issued only in IDLE. mem_req is issued in
// the same cycle as gnt. The owner's rvalid is a one-cycle pulse, raised on
// mem_rvalid or on timeout. A mem_rvalid seen while IDLE is dropped.
module rv32i_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [3:0]        ls_be,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state;
  logic             owner;     // 0 = IF, 1 = LS
  logic [CNT_W-1:0] wait_cnt;

  logic pick_ls;
  logic idle_grant;
  logic done_mem;
  logic timeout;
  logic complete;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  // In a contest, the requester that did not win last time wins now.
  always_comb begin
    pick_ls = ls_req & (~if_req | ~last_owner);
  end
`else
  // LS has fixed priority over IF.
  always_comb begin
    pick_ls = ls_req;
  end
`endif

  // Decode the events for this cycle. Every event is gated by reset so that
  // all outputs stay low while rst is asserted.
  always_comb begin
    idle_grant = rst & (state == IDLE) & (if_req | ls_req);
    done_mem   = rst & (state == WAIT) & mem_rvalid;
    timeout    = rst & (state == WAIT) & ~mem_rvalid & (wait_cnt == CNT_LAST);
    complete   = done_mem | timeout;
  end

  // Combinational grant, memory request and response steering.
  always_comb begin
    if_gnt    = idle_grant & ~pick_ls;
    ls_gnt    = idle_grant & pick_ls;
    mem_req   = idle_grant;
    mem_we    = idle_grant & pick_ls & ls_we;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (idle_grant) begin
      if (pick_ls) begin
        mem_be    = ls_be;
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
      end else begin
        mem_be    = 4'hF;
        mem_addr  = if_addr;
      end
    end
    if_rvalid = complete & ~owner;
    ls_rvalid = complete & owner;
    // On a timeout the owner gets rdata = 0, not the memory bus value.
    if_rdata  = (done_mem & ~owner) ? mem_rdata : '0;
    ls_rdata  = (done_mem & owner)  ? mem_rdata : '0;
    busy      = rst & (state == WAIT);
    err       = timeout;
  end

  // Control FSM: IDLE grants and launches a request. WAIT counts cycles until
  // the memory completes or the timeout fires.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      wait_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (if_req | ls_req) begin
            state    <= WAIT;
            owner    <= pick_ls;
            wait_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= pick_ls;
`endif
          end
        end
        WAIT: begin
          if (complete) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter
// Randomized and directed stimulus for rv32i_mem_arbiter.
// The expected results come from a transaction-level reference:
//  - an expected grant-order queue built from the arbitration rule,
//  - a word-array memory model,
//  - a latency or timeout rule applied to each transaction.
// If ARB_ROUND_ROBIN_EN is defined, the reference uses the alternating
// contest rule instead of fixed LS priority.
module tb_rv32i_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [3:0]        ls_be;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              err;

  rv32i_mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_be     (ls_be),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err       (err)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks;
  int          n_pass;
  logic [0:0]  exp_q[$];         // expected grant order: 0 = IF, 1 = LS
  logic        last_grant;       // requester that won the most recent grant
  logic [31:0] mem_model [0:15]; // word-indexed by address bits [5:2]

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Checks that every control output is low and both rdata buses are zero.
  task automatic check_quiet(input string tag);
    @(negedge clk);
    check(tag, {25'd0, if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, busy, err}, 32'd0);
    check({tag, "_rdata"}, if_rdata | ls_rdata, 32'd0);
  endtask

  // Runs one transaction. The call starts in the grant cycle, with the
  // winner's request already driven. A latency k <= TIMEOUT means the memory
  // responds k cycles after the grant. A larger k means the memory never
  // responds, so the timeout fires.
  task automatic run_txn(input logic own, input int k);
    logic [31:0] rd;
    logic [31:0] exp_addr;
    logic [3:0]  idx;
    exp_addr = own ? ls_addr : if_addr;
    idx      = exp_addr[5:2];
    @(negedge clk);
    check("if_gnt",   {31'd0, if_gnt}, {31'd0, ~own});
    check("ls_gnt",   {31'd0, ls_gnt}, {31'd0, own});
    check("mem_req",  {31'd0, mem_req}, 32'd1);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_we",   {31'd0, mem_we}, {31'd0, own & ls_we});
    check("mem_be",   {28'd0, mem_be}, own ? {28'd0, ls_be} : 32'hF);
    if (own && ls_we) check("mem_wdata", mem_wdata, ls_wdata);
    check("busy_at_grant", {31'd0, busy}, 32'd0);
    if (own && ls_we) begin
      for (int b = 0; b < 4; b++)
        if (ls_be[b]) mem_model[idx][8*b +: 8] = ls_wdata[8*b +: 8];
      rd = $urandom;
    end else begin
      rd = mem_model[idx];
    end
    next_cycle();
    if (own) ls_req = 1'b0;
    else     if_req = 1'b0;
    for (int j = 1; j < TIMEOUT && j < k; j++) begin
      @(negedge clk);
      check("wait_stall", {25'd0, if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid, err, busy}, 32'd1);
      next_cycle();
    end
    if (k <= TIMEOUT) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
    end
    @(negedge clk);
    check("rvalid_owner", {31'd0, own ? ls_rvalid : if_rvalid}, 32'd1);
    check("rvalid_other", {31'd0, own ? if_rvalid : ls_rvalid}, 32'd0);
    check("rdata_owner",  own ? ls_rdata : if_rdata, (k <= TIMEOUT) ? rd : 32'd0);
    check("rdata_other",  own ? if_rdata : ls_rdata, 32'd0);
    check("err",          {31'd0, err}, (k > TIMEOUT) ? 32'd1 : 32'd0);
    check("busy_at_done", {31'd0, busy}, 32'd1);
    next_cycle();
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
  endtask

  // Raises the requested reqs in the current cycle and predicts the grant
  // order from the arbitration rule. Each transaction then runs in turn.
  task automatic scenario(input bit want_if, input bit want_ls, input int k1, input int k2);
    logic first;
    logic own;
    int   n;
    if_req = want_if;
    ls_req = want_ls;
    if (want_if && want_ls) begin
      first = RR ? ~last_grant : 1'b1;
      exp_q.push_back(first);
      exp_q.push_back(~first);
    end else if (want_if || want_ls) begin
      exp_q.push_back(want_ls);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      own        = exp_q.pop_front();
      last_grant = own;
      run_txn(own, (n == 0) ? k1 : k2);
      n++;
    end
  endtask

  function automatic int rand_lat();
    if ($urandom_range(0, 7) == 0) return TIMEOUT + 1;
    return $urandom_range(1, TIMEOUT);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    n_checks   = 0;
    n_pass     = 0;
    last_grant = 1'b0;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    rst        = 1'b0;
    if_req     = 1'b1;
    ls_req     = 1'b1;
    if_addr    = '0;
    ls_we      = 1'b0;
    ls_be      = 4'h0;
    ls_addr    = '0;
    ls_wdata   = '0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;

    // Reset with both requests and a memory response held high.
    #1;
    check_quiet("reset_c0");
    next_cycle();
    check_quiet("reset_c1");
    next_cycle();
    rst        = 1'b1;
    if_req     = 1'b0;
    ls_req     = 1'b0;
    mem_rvalid = 1'b0;
    check_quiet("after_reset");
    next_cycle();

    // IF read at 0x100 with latency 3.
    if_addr      = 32'h100;
    mem_model[0] = 32'h0000_0013;
    scenario(1'b1, 1'b0, 3, 0);

    // Contest with latency 1, run twice.
    if_addr = 32'h104;
    ls_addr = 32'h108;
    ls_we   = 1'b0;
    ls_be   = 4'hF;
    scenario(1'b1, 1'b1, 1, 1);
    scenario(1'b1, 1'b1, 1, 1);

    // LS store with partial byte enables.
    ls_we    = 1'b1;
    ls_be    = 4'b0011;
    ls_addr  = 32'h2000;
    ls_wdata = 32'hAABB_CCDD;
    scenario(1'b0, 1'b1, 2, 0);

    // IF read that times out.
    if_addr = 32'h10C;
    scenario(1'b1, 1'b0, TIMEOUT + 1, 0);

    // A stray memory response while IDLE is dropped.
    mem_rvalid = 1'b1;
    check_quiet("stray_idle");
    next_cycle();
    mem_rvalid = 1'b0;

    // Reset during WAIT; the late response after release is ignored.
    if_req  = 1'b1;
    if_addr = 32'h110;
    @(negedge clk);
    check("midrst_gnt", {31'd0, if_gnt}, 32'd1);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    next_cycle();
    rst = 1'b0;
    check_quiet("midrst_r0");
    next_cycle();
    check_quiet("midrst_r1");
    next_cycle();
    rst        = 1'b1;
    last_grant = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    check_quiet("midrst_late");
    next_cycle();
    mem_rvalid = 1'b0;

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      if_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      ls_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      ls_we    = 1'($urandom_range(0, 1));
      ls_be    = 4'($urandom_range(0, 15));
      ls_wdata = $urandom;
      case ($urandom_range(0, 3))
        0:       scenario(1'b1, 1'b0, rand_lat(), 0);
        1:       scenario(1'b0, 1'b1, rand_lat(), 0);
        2:       scenario(1'b1, 1'b1, rand_lat(), rand_lat());
        default: begin
          mem_rvalid = 1'b1;
          mem_rdata  = $urandom;
          check_quiet("rand_stray");
          next_cycle();
          mem_rvalid = 1'b0;
        end
      endcase
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
